// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU activation path.
// Holds the feeder FSM encoding and the lane slicing helper
// used to address one WIDTH-bit element inside a packed vector.
package npu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

    // LSB position of lane j inside a packed N*WIDTH vector.
    function automatic int lane_lsb(input int j, input int width);
        return j * width;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Purpose: DEPTH-stage shift register carrying one lane's data and valid.
// Latency: DEPTH cycles from in_data/in_valid to out_data/out_valid.
// Backpressure: none; shifts every cycle, synchronous clear on rst.
module skew_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    logic [DEPTH-1:0][WIDTH-1:0] sr_dat;
    logic [DEPTH-1:0]            sr_vld;

    // Shift the lane one stage per cycle; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_dat <= '0;
            sr_vld <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sr_dat[i] <= sr_dat[i-1];
                sr_vld[i] <= sr_vld[i-1];
            end
            sr_dat[0] <= in_data;
            sr_vld[0] <= in_valid;
        end
    end

    assign out_data  = sr_dat[DEPTH-1];
    assign out_valid = sr_vld[DEPTH-1];

endmodule

// File: rtl/activation_skew_feeder.sv
// Purpose: skews N-lane activation vectors diagonally for the PE array top row.
// Latency: lane j of a vector accepted at cycle t appears at t+1+j; done at t+N after last.
// Backpressure: in_ready low only while draining (and during rst); bubbles shift in zeros.
module activation_skew_feeder
    import npu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [N*WIDTH-1:0] out_col,
    output logic [N-1:0]     out_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    feeder_state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic          accept;

    assign in_ready = !rst && (state != DRAIN);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    // Next-state decode; an accepted last vector always leads to the drain phase.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = in_last ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (accept && in_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, drain counter and done pulse; done lines up with lane N-1 showing the last element.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == DRAIN) && (cnt == CW'(1));
            if ((state != DRAIN) && (state_nxt == DRAIN)) begin
                cnt <= CW'(N - 1);
            end else if (state == DRAIN) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [WIDTH-1:0] head_dat;

        // Non-accept cycles feed zeros so the array sees no contribution.
        assign head_dat = accept ? in_data[lane_lsb(j, WIDTH) +: WIDTH] : '0;

        skew_delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (j + 1)
        ) u_line (
            .clk       (clk),
            .rst       (rst),
            .in_data   (head_dat),
            .in_valid  (accept),
            .out_data  (out_col[lane_lsb(j, WIDTH) +: WIDTH]),
            .out_valid (out_valid[j])
        );
    end

endmodule

// File: tb/tb_activation_skew_feeder.sv
// Directed bench for activation_skew_feeder with N=4, WIDTH=16.
// Inputs are driven and outputs sampled 1ns after each rising edge.
// Cycle cK is the cycle whose closing edge is the K-th edge after stimulus start.
module tb_activation_skew_feeder;

    localparam int WIDTH = 16;
    localparam int N     = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic              in_last;
    logic [N*WIDTH-1:0] out_col;
    logic [N-1:0]      out_valid;
    logic              busy;
    logic              done;

    int checks;
    int errors;

    activation_skew_feeder #(
        .WIDTH (WIDTH),
        .N     (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_col   (out_col),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*WIDTH-1:0] pack(input logic [15:0] l0, input logic [15:0] l1,
                                                 input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [WIDTH-1:0] lane(input int j);
        return out_col[j*WIDTH +: WIDTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = pack(16'd9, 16'd9, 16'd9, 16'd9);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (out_col !== '0) begin
                errors++; $display("FAIL reset_out_col: got %0h expected 0", out_col);
            end
            checks++;
            if (out_valid !== 4'b0000) begin
                errors++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
            end
            checks++;
            if (done !== 1'b0) begin
                errors++; $display("FAIL reset_done: got %b expected 0", done);
            end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_release_busy: got %b expected 0", busy);
        end
        idle(1);
    endtask

    task automatic test_single();
        logic [3:0] exp_v;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = pack(16'd1, 16'd2, 16'd3, 16'd4);
        for (int c = 1; c <= 4; c++) begin
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = '0;
            exp_v = 4'b0001 << (c - 1);
            checks++;
            if (lane(c - 1) !== 16'(c)) begin
                errors++; $display("FAIL single_lane%0d_c%0d: got %0d expected %0d", c - 1, c, lane(c - 1), c);
            end
            checks++;
            if (out_valid !== exp_v) begin
                errors++; $display("FAIL single_valid_c%0d: got %b expected %b", c, out_valid, exp_v);
            end
            checks++;
            if (done !== (c == 4)) begin
                errors++; $display("FAIL single_done_c%0d: got %b expected %b", c, done, (c == 4));
            end
            checks++;
            if (in_ready !== (c == 4)) begin
                errors++; $display("FAIL single_in_ready_c%0d: got %b expected %b", c, in_ready, (c == 4));
            end
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL single_done_c5: got %b expected 0", done);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_last  = (k == 2);
            in_data  = pack(16'(10*k), 16'(10*k + 1), 16'(10*k + 2), 16'(10*k + 3));
            if (k > 0) begin
                checks++;
                if (in_ready !== 1'b1 || busy !== 1'b1) begin
                    errors++; $display("FAIL b2b_stream_c%0d: got ready=%b busy=%b expected 1 1", k, in_ready, busy);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        checks++;
        if (out_col !== pack(16'd20, 16'd11, 16'd2, 16'd0)) begin
            errors++; $display("FAIL b2b_col_c3: got %h expected %h", out_col, pack(16'd20, 16'd11, 16'd2, 16'd0));
        end
        checks++;
        if (out_valid !== 4'b0111) begin
            errors++; $display("FAIL b2b_valid_c3: got %b expected 0111", out_valid);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_in_ready_c3: got %b expected 0", in_ready);
        end
        tick();
        tick();
        checks++;
        if (lane(3) !== 16'd13 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_c5: got lane3=%0d done=%b expected 13 0", lane(3), done);
        end
        tick();
        checks++;
        if (lane(3) !== 16'd23 || done !== 1'b1) begin
            errors++; $display("FAIL b2b_c6: got lane3=%0d done=%b expected 23 1", lane(3), done);
        end
        checks++;
        if (out_valid !== 4'b1000) begin
            errors++; $display("FAIL b2b_valid_c6: got %b expected 1000", out_valid);
        end
        idle(2);
    endtask

    task automatic test_bubble();
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = pack(16'd101, 16'd102, 16'd103, 16'd104);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        checks++;
        if (out_valid[0] !== 1'b1 || lane(0) !== 16'd101) begin
            errors++; $display("FAIL bubble_c1: got v=%b d=%0d expected 1 101", out_valid[0], lane(0));
        end
        tick();
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = pack(16'd201, 16'd202, 16'd203, 16'd204);
        checks++;
        if (out_valid[0] !== 1'b0 || lane(0) !== 16'd0) begin
            errors++; $display("FAIL bubble_c2: got v=%b d=%0d expected 0 0", out_valid[0], lane(0));
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL bubble_state_c2: got ready=%b busy=%b expected 1 1", in_ready, busy);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        checks++;
        if (out_valid[0] !== 1'b1 || lane(0) !== 16'd201) begin
            errors++; $display("FAIL bubble_c3: got v=%b d=%0d expected 1 201", out_valid[0], lane(0));
        end
        tick();
        checks++;
        if (out_valid[3] !== 1'b1 || lane(3) !== 16'd104) begin
            errors++; $display("FAIL bubble_lane3_c4: got v=%b d=%0d expected 1 104", out_valid[3], lane(3));
        end
        tick();
        checks++;
        if (out_valid[3] !== 1'b0 || lane(3) !== 16'd0) begin
            errors++; $display("FAIL bubble_lane3_c5: got v=%b d=%0d expected 0 0", out_valid[3], lane(3));
        end
        tick();
        checks++;
        if (out_valid[3] !== 1'b1 || lane(3) !== 16'd204 || done !== 1'b1) begin
            errors++; $display("FAIL bubble_lane3_c6: got v=%b d=%0d done=%b expected 1 204 1", out_valid[3], lane(3), done);
        end
        idle(2);
    endtask

    task automatic test_sign();
        logic [15:0] sv [4];
        sv[0] = 16'h8000;
        sv[1] = 16'hFFFF;
        sv[2] = 16'h7FFF;
        sv[3] = 16'h0000;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = pack(sv[0], sv[1], sv[2], sv[3]);
        for (int c = 1; c <= 4; c++) begin
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = '0;
            checks++;
            if (lane(c - 1) !== sv[c - 1] || out_valid[c - 1] !== 1'b1) begin
                errors++; $display("FAIL sign_lane%0d: got %h v=%b expected %h 1", c - 1, lane(c - 1), out_valid[c - 1], sv[c - 1]);
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = pack(16'd1, 16'd2, 16'd3, 16'd4);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        checks++;
        if (lane(0) !== 16'd1) begin
            errors++; $display("FAIL rmid_c1: got %0d expected 1", lane(0));
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rmid_in_ready_c2: got %b expected 0", in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_col !== '0 || out_valid !== 4'b0000) begin
            errors++; $display("FAIL rmid_clear_c3: got col=%h v=%b expected 0 0000", out_col, out_valid);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_idle_c3: got busy=%b done=%b ready=%b expected 0 0 1", busy, done, in_ready);
        end
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = pack(16'd5, 16'd6, 16'd7, 16'd8);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL rmid_no_done_c4: got %b expected 0", done);
        end
        checks++;
        if (lane(0) !== 16'd5 || out_valid !== 4'b0001) begin
            errors++; $display("FAIL rmid_new_c4: got d=%0d v=%b expected 5 0001", lane(0), out_valid);
        end
        tick();
        tick();
        tick();
        checks++;
        if (lane(3) !== 16'd8 || done !== 1'b1) begin
            errors++; $display("FAIL rmid_new_c7: got lane3=%0d done=%b expected 8 1", lane(3), done);
        end
        idle(2);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_bubble();
        test_sign();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
